mmio_timer_gpio: RTL and testbench
==================================

# mmio_timer_gpio

Memory-mapped peripheral that responds to the CPU's data-memory port (`we`, `addr`, `wr_data`, `rd_data`), the target side of the store/load path. It provides a prescaled 32-bit timer with a compare match, a sticky match flag, an interrupt line, and a small GPIO block. The top level decodes `hit` to choose between this block and `Data_Mem` when selecting load data. Reads are combinational to match the single-cycle datapath. Writes commit on the clock edge.

## Interface
- `BASE_ADDR`, default 32'h0000_8000: base of the 32-byte register window. Aligned to 32 bytes.
- `GPIO_W`, default 8: GPIO width, 1..32.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset. One clock; reset is synchronous and active-low.
- `we`  in  1  store strobe from the controller's `Mem_Write`.
- `addr`  in  32  byte address, the ALU result. `addr[1:0]` is ignored.
- `wr_data`  in  32  store data, the rt register value.
- `rd_data`  out  32  load data. Combinational. 0 when `hit`=0.
- `hit`  out  1  combinational: `addr[31:5] == BASE_ADDR[31:5]`.
- `gpio_in`  in  GPIO_W  asynchronous external inputs.
- `gpio_out`  out  GPIO_W  registered outputs.
- `irq`  out  1  level interrupt = `MATCH & IRQ_EN`. Driven from flops only.

## Operation
Word offsets are decoded from `addr[4:2]`. A write happens when `we & hit` at the rising edge.
- 0x00 CTRL (R/W, reset 0):
  - bit0 EN
  - bit1 AUTO_RELOAD
  - bit2 IRQ_EN
  - bits[15:8] PRESCALE
  - other bits read 0.
- 0x04 COUNT (R/W, reset 0). A write loads the value.
- 0x08 COMPARE (R/W, reset 32'hFFFF_FFFF).
- 0x0C STATUS:
  - bit0 MATCH: sticky, write-1-to-clear, reset 0.
  - bit1 RUNNING: read-only copy of EN.
  - other bits read 0, and writing them has no effect.
- 0x10 GPIO_OUT (R/W, reset 0). Only the low GPIO_W bits are stored; upper bits read 0.
- 0x14 GPIO_IN (RO): `gpio_in` passed through a 2-flop synchronizer, zero-extended. Writes are ignored.
- 0x18, 0x1C: read 0, writes ignored.

Prescaler:
- 8-bit `pre_cnt`, reset 0.
- While EN=1: if `pre_cnt == PRESCALE`, set `pre_cnt` to 0 and assert `tick` for one cycle. Otherwise increment `pre_cnt`.
- A tick therefore occurs every PRESCALE+1 cycles. PRESCALE=0 gives a tick every cycle.
- While EN=0, `pre_cnt` holds 0 and there are no ticks.
- Any CTRL write clears `pre_cnt` to 0 on that edge.

Counter, on each tick:
- If COUNT == COMPARE: set MATCH to 1, and COUNT becomes 0 if AUTO_RELOAD=1, otherwise COUNT+1.
- Otherwise COUNT becomes COUNT+1.
- The addition wraps modulo 2^32 (32'hFFFF_FFFF goes to 0). There is no overflow flag.

Simultaneous events:
- COUNT write in the same edge as a tick: the written value is stored. No increment, and no compare is evaluated for that tick.
- STATUS W1C of MATCH in the same edge as a new match: set wins, MATCH stays 1.
- COMPARE write in the same edge as a tick: the compare uses the old COMPARE value.
- CTRL write setting EN=0: no tick fires on that edge, even if `pre_cnt == PRESCALE`.

Reset:
- When `rst_n`=0 at an edge, every register, `pre_cnt` and both synchronizer stages take their reset values.
- Reset wins over a concurrent write.
- Reset asserted mid-count aborts the count. There is no residual state.

## Timing
- Write latency: a register takes its new value at the edge where `we & hit`. `rd_data` shows it in the following cycle.
- Read latency: 0 cycles. `rd_data` follows `addr` within the same cycle.
- `rd_data` for COUNT shows the pre-edge value during the cycle containing the tick.
- GPIO_IN latency: a `gpio_in` change becomes visible in `rd_data` after 2 rising edges.
- `irq` latency: `irq` rises one edge after the tick that sets MATCH (IRQ_EN=1). It falls one edge after the W1C or after IRQ_EN is cleared.
- Outputs in reset:
  - `gpio_out`=0
  - `irq`=0
  - `rd_data` = decoded reset values (COMPARE reads FFFF_FFFF; COUNT, CTRL, STATUS, GPIO_OUT read 0).
  - `hit` is purely address-dependent.
- No wait states or handshake. Every access completes in one cycle.

## Test plan
- Reset and readback: release `rst_n`, read 0x00 through 0x1C at base 0x8000 → 0, 0, FFFF_FFFF, 0, 0, sync'd GPIO, 0, 0. Read 0x8020 → `hit`=0, `rd_data`=0.
- Prescale/match: write COMPARE=5, then CTRL=0x0000_0307 (PRESCALE=3, EN, AUTO_RELOAD, IRQ_EN) → COUNT advances every 4 cycles; after the tick at COUNT=5, COUNT=0, MATCH=1, `irq`=1 one edge later; write STATUS=1 → `irq`=0 next cycle.
- Wrap without reload: COUNT=FFFF_FFFE, COMPARE=0, CTRL=0x1 → after 2 ticks COUNT=0, MATCH=0; after the third tick MATCH=1, COUNT=1.
- Collisions, at PRESCALE=0:
  - COUNT write 0x100 on a tick edge → reads 0x100, not 0x101.
  - W1C on a matching tick → MATCH stays 1.
- GPIO: write 0x10=0xFFFF_FFA5 with GPIO_W=8 → `gpio_out`=0xA5, readback 0xA5. Drive `gpio_in`=0x3C → readback 0x3C after 2 edges, old value after 1.
- Mid-operation reset: running timer at COUNT=0x40 with MATCH=1, assert `rst_n`=0 for 1 edge during a write to GPIO_OUT → all registers reset, `gpio_out`=0, `irq`=0.

Source files
------------

// File: rtl/mmio_timer_gpio_if.sv
// Data-memory port bundle between the CPU store/load path and the
// timer/GPIO peripheral. The CPU drives the request; the peripheral
// answers with combinational load data and an address-hit flag.
interface mmio_timer_gpio_if;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        hit;

  modport master (
    output we,
    output addr,
    output wr_data,
    input  rd_data,
    input  hit
  );

  modport slave (
    input  we,
    input  addr,
    input  wr_data,
    output rd_data,
    output hit
  );
endinterface

// File: rtl/mmio_timer_gpio.sv
// Memory-mapped timer + GPIO peripheral.
// 32-byte register window: CTRL, COUNT, COMPARE, STATUS, GPIO_OUT, GPIO_IN.
// Prescaled 32-bit up-counter with compare match, sticky W1C match flag,
// level interrupt from flops, and a synchronized GPIO input path.
// Reads are combinational; writes and timer state update on the rising edge.
module mmio_timer_gpio #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_8000,
  parameter int          GPIO_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mmio_timer_gpio_if.slave  bus,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              irq
);

  localparam logic [2:0] OFF_CTRL    = 3'd0;
  localparam logic [2:0] OFF_COUNT   = 3'd1;
  localparam logic [2:0] OFF_COMPARE = 3'd2;
  localparam logic [2:0] OFF_STATUS  = 3'd3;
  localparam logic [2:0] OFF_GPIO_O  = 3'd4;
  localparam logic [2:0] OFF_GPIO_I  = 3'd5;

  // Register state
  logic              en_reg;
  logic              auto_reload_reg;
  logic              irq_en_reg;
  logic [7:0]        prescale_reg;
  logic [7:0]        pre_cnt_reg;
  logic [31:0]       count_reg;
  logic [31:0]       compare_reg;
  logic              match_reg;
  logic              irq_reg;
  logic [GPIO_W-1:0] gpio_out_reg;
  logic [GPIO_W-1:0] gpio_meta_reg;
  logic [GPIO_W-1:0] gpio_sync_reg;

  // Address decode
  logic       hit_w;
  logic [2:0] sel;
  logic       wr_en;
  logic       ctrl_wr;
  logic       count_wr;
  logic       compare_wr;
  logic       status_wr;
  logic       gpio_out_wr;
  logic       tick;
  logic       count_match;
  logic       unused_addr_bits;

  assign hit_w       = (bus.addr[31:5] == BASE_ADDR[31:5]);
  assign sel         = bus.addr[4:2];
  assign wr_en       = bus.we & hit_w;
  assign ctrl_wr     = wr_en && (sel == OFF_CTRL);
  assign count_wr    = wr_en && (sel == OFF_COUNT);
  assign compare_wr  = wr_en && (sel == OFF_COMPARE);
  assign status_wr   = wr_en && (sel == OFF_STATUS);
  assign gpio_out_wr = wr_en && (sel == OFF_GPIO_O);

  // Byte-lane bits of the address carry no meaning for word registers.
  assign unused_addr_bits = &{1'b0, bus.addr[1:0]};

  // A CTRL write that clears EN suppresses a tick that would otherwise fire
  // on the same edge, so the counter stops exactly where software left it.
  assign tick        = en_reg && (pre_cnt_reg == prescale_reg) &&
                       !(ctrl_wr && !bus.wr_data[0]);
  assign count_match = (count_reg == compare_reg);

  // CTRL fields
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_reg          <= 1'b0;
      auto_reload_reg <= 1'b0;
      irq_en_reg      <= 1'b0;
      prescale_reg    <= 8'd0;
    end else if (ctrl_wr) begin
      en_reg          <= bus.wr_data[0];
      auto_reload_reg <= bus.wr_data[1];
      irq_en_reg      <= bus.wr_data[2];
      prescale_reg    <= bus.wr_data[15:8];
    end
  end

  // Prescaler: counts 0..PRESCALE while enabled, restarts on any CTRL write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt_reg <= 8'd0;
    end else if (ctrl_wr || !en_reg || (pre_cnt_reg == prescale_reg)) begin
      pre_cnt_reg <= 8'd0;
    end else begin
      pre_cnt_reg <= pre_cnt_reg + 8'd1;
    end
  end

  // Counter: software load has priority over a tick on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= 32'd0;
    end else if (count_wr) begin
      count_reg <= bus.wr_data;
    end else if (tick) begin
      if (count_match && auto_reload_reg) begin
        count_reg <= 32'd0;
      end else begin
        count_reg <= count_reg + 32'd1;
      end
    end
  end

  // COMPARE register; a same-edge tick compares against the old value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      compare_reg <= 32'hFFFF_FFFF;
    end else if (compare_wr) begin
      compare_reg <= bus.wr_data;
    end
  end

  // Sticky MATCH flag: a new match beats a concurrent write-1-to-clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match_reg <= 1'b0;
    end else if (tick && !count_wr && count_match) begin
      match_reg <= 1'b1;
    end else if (status_wr && bus.wr_data[0]) begin
      match_reg <= 1'b0;
    end
  end

  // Interrupt line registered from the flag and enable flops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_reg <= 1'b0;
    end else begin
      irq_reg <= match_reg & irq_en_reg;
    end
  end

  // GPIO output register and two-stage input synchronizer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gpio_out_reg  <= '0;
      gpio_meta_reg <= '0;
      gpio_sync_reg <= '0;
    end else begin
      if (gpio_out_wr) begin
        gpio_out_reg <= bus.wr_data[GPIO_W-1:0];
      end
      gpio_meta_reg <= gpio_in;
      gpio_sync_reg <= gpio_meta_reg;
    end
  end

  // Combinational load-data mux; zero outside the window and in holes
  logic [31:0] rd_data_next;
  always_comb begin
    rd_data_next = 32'd0;
    if (hit_w) begin
      case (sel)
        OFF_CTRL:    rd_data_next = {16'd0, prescale_reg, 5'd0,
                                     irq_en_reg, auto_reload_reg, en_reg};
        OFF_COUNT:   rd_data_next = count_reg;
        OFF_COMPARE: rd_data_next = compare_reg;
        OFF_STATUS:  rd_data_next = {30'd0, en_reg, match_reg};
        OFF_GPIO_O:  rd_data_next = 32'(gpio_out_reg);
        OFF_GPIO_I:  rd_data_next = 32'(gpio_sync_reg);
        default:     rd_data_next = 32'd0;
      endcase
    end
  end

  assign bus.rd_data = rd_data_next;
  assign bus.hit     = hit_w;
  assign gpio_out    = gpio_out_reg;
  assign irq         = irq_reg;

endmodule

// File: tb/tb_mmio_timer_gpio.sv
// Directed bench for mmio_timer_gpio with a scoreboard queue.
// The driver steps one cycle at a time (inputs changed 1 time unit after
// the rising edge) and pushes expected values; the monitor pops and
// compares every queued entry on the following falling edge.
module tb_mmio_timer_gpio;

  localparam logic [31:0] A_CTRL = 32'h0000_8000;
  localparam logic [31:0] A_CNT  = 32'h0000_8004;
  localparam logic [31:0] A_CMP  = 32'h0000_8008;
  localparam logic [31:0] A_STAT = 32'h0000_800C;
  localparam logic [31:0] A_GOUT = 32'h0000_8010;
  localparam logic [31:0] A_GIN  = 32'h0000_8014;

  localparam int K_RD   = 0;
  localparam int K_IRQ  = 1;
  localparam int K_GOUT = 2;
  localparam int K_HIT  = 3;

  logic       clk;
  logic       rst_n;
  logic [7:0] gpio_in;
  logic [7:0] gpio_out;
  logic       irq;

  mmio_timer_gpio_if bus_if ();

  mmio_timer_gpio #(
    .BASE_ADDR(32'h0000_8000),
    .GPIO_W   (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus_if),
    .gpio_in (gpio_in),
    .gpio_out(gpio_out),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    string       name;
    logic [31:0] exp;
  } chk_t;

  chk_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  // Monitor: compare everything queued for this cycle
  always @(negedge clk) begin
    chk_t        c;
    logic [31:0] act;
    while (sb_q.size() > 0) begin
      c = sb_q.pop_front();
      case (c.kind)
        K_RD:    act = bus_if.rd_data;
        K_IRQ:   act = {31'd0, irq};
        K_GOUT:  act = {24'd0, gpio_out};
        default: act = {31'd0, bus_if.hit};
      endcase
      tests++;
      if (act !== c.exp) begin
        fails++;
        $display("FAIL %s: got %h, expected %h", c.name, act, c.exp);
      end else begin
        $display("[TB] ok   %s = %h", c.name, act);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_sig(input int kind, input string name, input logic [31:0] v);
    chk_t c;
    c.kind = kind;
    c.name = name;
    c.exp  = v;
    sb_q.push_back(c);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_if.addr    = a;
    bus_if.wr_data = d;
    bus_if.we      = 1'b1;
    step();
    bus_if.we      = 1'b0;
  endtask

  // Check load data for the state present before the next edge, then take it
  task automatic rd(input logic [31:0] a, input logic [31:0] v, input string name);
    bus_if.addr = a;
    bus_if.we   = 1'b0;
    expect_sig(K_RD, name, v);
    step();
  endtask

  // Watchdog: the bench is purely cycle-stepped, this only guards a stall
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus_if.we      = 1'b0;
    bus_if.addr    = 32'd0;
    bus_if.wr_data = 32'd0;
    gpio_in        = 8'd0;
    step();
    step();

    // Outputs while held in reset
    expect_sig(K_GOUT, "rst_gpio_out", 32'd0);
    expect_sig(K_IRQ, "rst_irq", 32'd0);
    rd(A_CMP, 32'hFFFF_FFFF, "rst_compare");
    rst_n = 1'b1;

    // Reset readback of the whole window and one address past it
    expect_sig(K_HIT, "hit_base", 32'd1);
    rd(A_CTRL, 32'd0, "rb_ctrl");
    rd(A_CNT, 32'd0, "rb_count");
    rd(A_CMP, 32'hFFFF_FFFF, "rb_compare");
    rd(A_STAT, 32'd0, "rb_status");
    rd(A_GOUT, 32'd0, "rb_gpio_out");
    rd(A_GIN, 32'd0, "rb_gpio_in");
    rd(32'h0000_8018, 32'd0, "rb_0x18");
    rd(32'h0000_801C, 32'd0, "rb_0x1c");
    expect_sig(K_HIT, "miss_hit", 32'd0);
    rd(32'h0000_8020, 32'd0, "miss_rd");

    tests++;
    if (bus_if.hit !== 1'b0) begin
      fails++;
      $display("FAIL miss_hit_direct: got %b, expected 0", bus_if.hit);
    end else begin
      $display("[TB] ok   miss_hit_direct = %b", bus_if.hit);
    end
    tests++;
    if (bus_if.rd_data !== 32'd0) begin
      fails++;
      $display("FAIL miss_rd_direct: got %h, expected 00000000", bus_if.rd_data);
    end else begin
      $display("[TB] ok   miss_rd_direct = %h", bus_if.rd_data);
    end

    // Prescale 3, compare 5, auto-reload, irq enabled
    wr(A_CMP, 32'd5);
    wr(A_CTRL, 32'h0000_0307);              // edge E0
    rd(A_CNT, 32'd0, "pre_after_e0");       // E1
    step();                                 // E2
    step();                                 // E3
    rd(A_CNT, 32'd0, "pre_after_e3");       // E4 is first tick
    rd(A_CNT, 32'd1, "pre_after_e4");       // E5
    repeat (18) step();                     // E6..E23
    expect_sig(K_IRQ, "irq_before_match", 32'd0);
    rd(A_CNT, 32'd5, "pre_count5");         // E24 tick matches
    expect_sig(K_IRQ, "irq_match_edge", 32'd0);
    rd(A_STAT, 32'd3, "match_set");         // E25
    expect_sig(K_IRQ, "irq_raised", 32'd1);
    rd(A_CNT, 32'd0, "auto_reload0");       // E26
    wr(A_STAT, 32'd1);                      // E27 W1C
    expect_sig(K_IRQ, "irq_lag_w1c", 32'd1);
    rd(A_STAT, 32'd2, "match_cleared");     // E28 tick
    expect_sig(K_IRQ, "irq_cleared", 32'd0);
    rd(A_CNT, 32'd1, "reload_running");
    wr(A_CTRL, 32'd0);

    // Wrap without reload, prescale 0
    wr(A_CNT, 32'hFFFF_FFFE);
    wr(A_CMP, 32'd0);
    wr(A_CTRL, 32'h0000_0001);              // E0
    rd(A_CNT, 32'hFFFF_FFFE, "wrap_start"); // E1 tick
    rd(A_STAT, 32'd2, "wrap_nomatch");      // E2 tick -> 0
    rd(A_CNT, 32'd0, "wrap_zero");          // E3 tick matches
    wr(A_CTRL, 32'd0);                      // E4: EN cleared, no tick
    rd(A_CNT, 32'd1, "wrap_one");
    rd(A_STAT, 32'd1, "wrap_match");

    // Collisions at prescale 0
    wr(A_STAT, 32'd1);
    wr(A_CMP, 32'h0000_0200);
    wr(A_CTRL, 32'h0000_0001);              // E0
    wr(A_CNT, 32'h0000_0100);               // E1 tick + load
    rd(A_CNT, 32'h0000_0100, "cnt_wr_collide");
    rd(A_CNT, 32'h0000_0101, "cnt_tick_after");
    wr(A_CMP, 32'h0000_0104);               // count -> 0x103
    step();                                 // count -> 0x104
    wr(A_STAT, 32'd1);                      // match vs W1C
    rd(A_STAT, 32'd3, "w1c_collide");       // count -> 0x106
    wr(A_CTRL, 32'd0);                      // no tick on this edge
    rd(A_CNT, 32'h0000_0106, "en_off_notick");

    // GPIO
    wr(A_GOUT, 32'hFFFF_FFA5);
    tests++;
    if (gpio_out !== 8'hA5) begin
      fails++;
      $display("FAIL gpio_out_direct: got %h, expected a5", gpio_out);
    end else begin
      $display("[TB] ok   gpio_out_direct = %h", gpio_out);
    end
    expect_sig(K_GOUT, "gpio_out_pin", 32'h0000_00A5);
    rd(A_GOUT, 32'h0000_00A5, "gpio_out_rb");
    gpio_in = 8'h3C;
    rd(A_GIN, 32'd0, "gin_0edge");
    rd(A_GIN, 32'd0, "gin_1edge");
    rd(A_GIN, 32'h0000_003C, "gin_2edge");
    wr(A_GIN, 32'd0);
    rd(A_GIN, 32'h0000_003C, "gin_wr_ignored");
    wr(32'h0000_8018, 32'h1234_5678);
    rd(32'h0000_8018, 32'd0, "hole_wr_ignored");

    // Mid-operation reset during a GPIO_OUT write
    wr(A_STAT, 32'd1);
    wr(A_CNT, 32'h0000_003F);
    wr(A_CMP, 32'h0000_003F);
    wr(A_CTRL, 32'h0000_0005);              // E0
    rd(A_CNT, 32'h0000_003F, "mr_count");   // E1 tick matches -> 0x40
    rd(A_STAT, 32'd3, "mr_match");          // E2, irq rises
    expect_sig(K_IRQ, "mr_irq_before", 32'd1);
    rst_n          = 1'b0;
    bus_if.we      = 1'b1;
    bus_if.addr    = A_GOUT;
    bus_if.wr_data = 32'h0000_005A;
    step();
    rst_n     = 1'b1;
    bus_if.we = 1'b0;
    tests++;
    if (gpio_out !== 8'h00) begin
      fails++;
      $display("FAIL mr_gpio_out_direct: got %h, expected 00", gpio_out);
    end else begin
      $display("[TB] ok   mr_gpio_out_direct = %h", gpio_out);
    end
    tests++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL mr_irq_direct: got %b, expected 0", irq);
    end else begin
      $display("[TB] ok   mr_irq_direct = %b", irq);
    end
    expect_sig(K_GOUT, "mr_gpio_out", 32'd0);
    expect_sig(K_IRQ, "mr_irq", 32'd0);
    rd(A_GIN, 32'd0, "mr_gpio_in");
    expect_sig(K_IRQ, "mr_irq_stays", 32'd0);
    rd(A_CNT, 32'd0, "mr_count_rst");
    rd(A_STAT, 32'd0, "mr_status");
    rd(A_CTRL, 32'd0, "mr_ctrl");
    rd(A_CMP, 32'hFFFF_FFFF, "mr_compare");
    rd(A_GOUT, 32'd0, "mr_gpio_out_rb");

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
